// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad column scanner.
// State encoding, matrix geometry and key_code field layout.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam logic [3:0] COL_ALL = 4'b1111;

    // key_code = {row_idx[1:0], col_idx[1:0]}
    localparam int KC_COL_LSB = 0;
    localparam int KC_ROW_LSB = 2;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        SCAN,
        HELD
    } state_t;

    // Lowest active row wins when several rows respond.
    function automatic logic [1:0] lowest_row(input logic [3:0] r);
        lowest_row = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (r[i]) lowest_row = 2'(i);
        end
    endfunction

    function automatic logic [3:0] col_onehot(input logic [1:0] idx);
        return 4'(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad-side signal bundle: row sense, column drive and key report.
// master = scanner, slave = keypad / environment.
interface keypad_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] row;
    logic                s_row;
    logic [NUM_COLS-1:0] col;
    logic [3:0]          key_code;
    logic                key_valid;
    logic                key_held;

    modport master (
        input  row,
        input  s_row,
        output col,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        output s_row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/keypad_scanner_debounce_counter.sv
// Saturating consecutive-condition counter with clear.
// done is high once the condition has held DEBOUNCE_CYCLES times.
module debounce_counter #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic step,
    output logic done
);
    localparam int W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign done = (cnt_q == W'(DEBOUNCE_CYCLES));

    // clear restarts the run; clear with step counts the current cycle
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = W'(step);
        end else if (step && !done) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: debounces press, scans columns,
// reports one key code per press and tracks the held key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SETTLE_CYCLES   = 2
) (
    input logic      clk,
    input logic      rst,
    keypad_if.master kp
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    logic [3:0]    row_meta_q;
    logic [3:0]    row_q;

    state_t        state_q, state_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [SW-1:0] set_cnt_q, set_cnt_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic          deb_clear;
    logic          deb_step;
    logic          deb_done;

    debounce_counter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .clear(deb_clear),
        .step (deb_step),
        .done (deb_done)
    );

    // Two-flop synchronizer on the raw row lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q <= '0;
            row_q      <= '0;
        end else begin
            row_meta_q <= kp.row;
            row_q      <= row_meta_q;
        end
    end

    // Next-state and registered-output logic for the scan FSM
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        set_cnt_d   = set_cnt_q;
        col_d       = col_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        deb_clear   = 1'b0;
        deb_step    = 1'b0;

        unique case (state_q)
            IDLE: begin
                col_d      = COL_ALL;
                key_held_d = 1'b0;
                deb_clear  = 1'b1;
                deb_step   = kp.s_row;
                if (kp.s_row) state_d = PRESS_DB;
            end
            PRESS_DB: begin
                if (!kp.s_row) begin
                    state_d   = IDLE;
                    deb_clear = 1'b1;
                end else if (deb_done) begin
                    state_d   = SCAN;
                    deb_clear = 1'b1;
                    col_idx_d = 2'd0;
                    set_cnt_d = '0;
                    col_d     = col_onehot(2'd0);
                end else begin
                    deb_step = 1'b1;
                end
            end
            SCAN: begin
                deb_clear = 1'b1;
                if (set_cnt_q == SW'(SETTLE_CYCLES)) begin
                    if (row_q != 4'b0000) begin
                        key_code_d[KC_ROW_LSB +: 2] = lowest_row(row_q);
                        key_code_d[KC_COL_LSB +: 2] = col_idx_q;
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        state_d     = HELD;
                    end else if (col_idx_q != 2'd3) begin
                        col_idx_d = col_idx_q + 2'd1;
                        set_cnt_d = '0;
                        col_d     = col_onehot(col_idx_q + 2'd1);
                    end else begin
                        state_d = IDLE;
                        col_d   = COL_ALL;
                    end
                end else begin
                    set_cnt_d = set_cnt_q + SW'(1);
                end
            end
            HELD: begin
                if (deb_done) begin
                    state_d    = IDLE;
                    key_held_d = 1'b0;
                    col_d      = COL_ALL;
                    deb_clear  = 1'b1;
                end else if (row_q == 4'b0000) begin
                    deb_step = 1'b1;
                end else begin
                    deb_clear = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                col_d   = COL_ALL;
            end
        endcase
    end

    // FSM state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_idx_q   <= '0;
            set_cnt_q   <= '0;
            col_q       <= COL_ALL;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            set_cnt_q   <= set_cnt_d;
            col_q       <= col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kp.col       = col_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a behavioural keypad matrix.
// Expected codes and latencies come from a column-then-row priority model.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int DEB = 4;
    localparam int SET = 2;

    typedef struct {
        logic [3:0] code;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keypad_if kp();

    keypad_scanner #(
        .DEBOUNCE_CYCLES(DEB),
        .SETTLE_CYCLES  (SET)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp (kp)
    );

    // keys[r*4+c] = switch at row r, column c is closed
    logic [15:0] keys;
    logic        glitch;
    logic [3:0]  row_v;

    always_comb begin
        row_v = '0;
        for (int r = 0; r < 4; r++) begin
            row_v[r] = |(keys[r*4 +: 4] & kp.col);
        end
    end

    assign kp.row   = row_v;
    assign kp.s_row = glitch | (|row_v);

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_chk = 0;
    int         n_fail = 0;
    exp_t       sb[$];
    logic [3:0] model_code;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scanning order: column 0..3, rows 0..3 within each column
    function automatic logic [3:0] ref_code(input logic [15:0] m);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (m[r*4 + c]) return 4'((r << 2) | c);
        return 4'd0;
    endfunction

    function automatic int ref_lat(input logic [15:0] m);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (m[r*4 + c]) return DEB + (c + 1) * (SET + 1) + 1;
        return 0;
    endfunction

    // Monitor: every valid pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (kp.key_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_valid: code %0d with nothing expected", kp.key_code);
                end else begin
                    e = sb.pop_front();
                    chk("key_code", kp.key_code, e.code);
                    chk("latency_cycle", cyc, e.due);
                    model_code = e.code;
                end
            end else begin
                chk("code_stable", kp.key_code, model_code);
            end
        end
    end

    task automatic press(input logic [15:0] m, input logic [15:0] extra, input int holdc);
        exp_t e;
        int   n;
        bit   got;
        @(negedge clk);
        keys   = m;
        e.code = ref_code(m);
        e.due  = cyc + ref_lat(m);
        sb.push_back(e);
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) got = 1;
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL valid_timeout: no key_valid for mask %h", m);
            sb.delete();
        end
        keys = keys | extra;
        repeat (holdc) @(negedge clk);
        chk("held_while_pressed", kp.key_held, 1);
        keys = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (kp.key_held && n < 30);
        chk("release_window", int'(n >= DEB + 1 && n <= DEB + 3), 1);
        chk("col_after_release", kp.col, COL_ALL);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [15:0] m;
        int          c0;
        bit          hit;
        keys       = '0;
        glitch     = 1'b0;
        model_code = '0;
        rst        = 1'b1;
        #3;
        chk("rst_col", kp.col, COL_ALL);
        chk("rst_code", kp.key_code, 0);
        chk("rst_valid", kp.key_valid, 0);
        chk("rst_held", kp.key_held, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Clean press r2,c1
        press(16'h0200, 16'h0000, 40);

        // Bounce: 2-cycle pulses never complete debounce
        @(negedge clk);
        repeat (2) begin
            keys = 16'h0200;
            repeat (2) begin
                @(negedge clk);
                chk("bounce_col", kp.col, COL_ALL);
            end
            keys = '0;
            repeat (2) begin
                @(negedge clk);
                chk("bounce_col", kp.col, COL_ALL);
            end
        end
        repeat (8) begin
            @(negedge clk);
            chk("bounce_col", kp.col, COL_ALL);
        end

        // Glitch: s_row debounced but no row responds in any column
        @(negedge clk);
        c0 = cyc;
        glitch = 1'b1;
        repeat (6) @(negedge clk);
        glitch = 1'b0;
        repeat (DEB + 4 * (SET + 1) - 6) @(negedge clk);
        chk("glitch_cycle", cyc, c0 + DEB + 4 * (SET + 1));
        chk("glitch_col3", kp.col, 4'b1000);
        @(negedge clk);
        chk("glitch_idle_col", kp.col, COL_ALL);
        repeat (6) @(negedge clk);

        // Two keys r3,c0 and r0,c2; third key r1,c0 while held
        press(16'h1004, 16'h0010, 15);

        // Latency check r1,c3
        press(16'h0080, 16'h0000, 10);

        // Reset mid-scan on column 2
        @(negedge clk);
        keys = 16'h0080;
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            if (kp.col == 4'b0100) hit = 1;
        end
        chk("reached_col2", int'(hit), 1);
        rst = 1'b1;
        #1;
        chk("midrst_col", kp.col, COL_ALL);
        chk("midrst_held", kp.key_held, 0);
        chk("midrst_valid", kp.key_valid, 0);
        chk("midrst_code", kp.key_code, 0);
        keys = '0;
        sb.delete();
        model_code = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        press(16'h0001, 16'h0000, 8);

        // Random multi-key presses
        repeat (10) begin
            m = '0;
            repeat ($urandom_range(1, 3)) m[$urandom_range(0, 15)] = 1'b1;
            press(m, 16'h0000, $urandom_range(5, 20));
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Column-scan controller for a 4x4 matrix keypad.
- Sits directly downstream of the row synchronizer. It consumes the synchronized "any row active" flag s_row and the raw row bus, drives the column lines, and debounces presses and releases.
- Emits one key code with a single-cycle valid pulse per debounced press.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a press/release condition must hold before it is accepted (>=1).
- SETTLE_CYCLES, 2, cycles each column is driven before rows are sampled (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- row  input  4  raw keypad row lines, active-high; internally double-flopped to row_q before use.
- s_row  input  1  synchronized OR of row from the upstream synchronizer.
- col  output  4  column drive, active-high.
- key_code  output  4  {row_idx[1:0], col_idx[1:0]}; holds last accepted key.
- key_valid  output  1  one-cycle pulse when key_code is updated.
- key_held  output  1  high while the accepted key remains pressed (until release debounced).

Behaviour:
- Reset values (async, immediate on rst=1): state=IDLE, col=4'b1111, key_code=0, key_valid=0, key_held=0, counters=0, row_q sync flops=0.
- Counters: deb_cnt width $clog2(DEBOUNCE_CYCLES+1), set_cnt width $clog2(SETTLE_CYCLES+1), col_idx 2 bits.
- IDLE: col=1111. s_row=1 -> PRESS_DB, deb_cnt=1.
- PRESS_DB: col=1111. s_row=1 increments deb_cnt. s_row=0 -> IDLE, deb_cnt=0.
  - Reaching deb_cnt==DEBOUNCE_CYCLES with s_row=1 -> SCAN, col_idx=0, set_cnt=0.
- SCAN: col=one-hot(col_idx); set_cnt increments each cycle.
  - At set_cnt==SETTLE_CYCLES, sample row_q.
  - row_q!=0: lowest set bit gives row_idx. Load key_code={row_idx,col_idx}, key_valid=1 for exactly that next cycle, key_held=1 -> HELD. col stays one-hot(col_idx).
  - row_q==0 and col_idx<3: col_idx+1, set_cnt=0, stay in SCAN.
  - row_q==0 and col_idx==3: spurious press -> IDLE, no key_valid.
- HELD: col held on found column; key_held=1.
  - row_q==0 increments deb_cnt; row_q!=0 clears it.
  - deb_cnt==DEBOUNCE_CYCLES -> IDLE, key_held=0, col=1111.
- Multiple simultaneous keys:
  - Lowest column scanned first wins; within it, lowest row index wins.
  - A second key pressed while HELD is ignored until full release.
- Latency: first rising clk with s_row=1 to key_valid = DEBOUNCE_CYCLES + (col_idx+1)*(SETTLE_CYCLES+1) + 1 cycles, exact and checked by bench.
- key_valid never asserts twice without an intervening return to IDLE.
- key_code is stable outside key_valid cycles.
- rst mid-scan or mid-HELD: everything returns to reset values asynchronously. No key_valid is produced for the interrupted press.

Decomposition:
- Shared package keypad_pkg:
  - state encoding typedef (IDLE, PRESS_DB, SCAN, HELD).
  - NUM_ROWS=4, NUM_COLS=4, COL_ALL=4'b1111.
  - key_code field positions.
- One natural sub-module: debounce_counter, a saturating consecutive-condition counter with clear, DEBOUNCE_CYCLES parameter and done flag. Reused in PRESS_DB and HELD.
- Row 2-flop synchronizer is inline (4 bits).

Test Plan:
- Clean press of key at row 2, col 1, held 40 cycles (DEBOUNCE_CYCLES=4, SETTLE_CYCLES=2) -> exactly one key_valid, key_code=4'b1001. key_held high until 4 cycles after release, then col=1111.
- Bounce: s_row/row toggle 1,0,1,0 with 2-cycle pulses -> never leaves PRESS_DB, no key_valid, col stays 1111.
- Row activity absent during all four scan columns (glitch after debounce) -> returns to IDLE after col 3 sample, no key_valid.
- Two keys: (row 3, col 0) and (row 0, col 2) pressed together -> key_code=4'b1100. Pressing a third key while HELD produces no extra pulse.
- Reset asserted asynchronously mid-SCAN (col=0100) -> col=1111, key_held=0, key_valid=0 immediately. Post-reset press of (row 0, col 0) -> key_code=0000 with one pulse.
- Latency check: press at col 3, row 1 -> key_valid exactly 4+4*3+1=17 cycles after first s_row=1 edge, key_code=4'b0111.
